// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire master: ROM commands, sequencer states, default timing.
// Timing values are in core clock cycles.
package onewire_pkg;

  localparam logic [7:0] CMD_READ_ROM  = 8'h33;
  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] CMD_MATCH_ROM = 8'h55;

  localparam int DEF_T_RSTL    = 480;
  localparam int DEF_T_MSP     = 70;
  localparam int DEF_T_RSTH    = 480;
  localparam int DEF_T_SLOT    = 70;
  localparam int DEF_T_LOW1    = 6;
  localparam int DEF_T_LOW0    = 60;
  localparam int DEF_T_MSR     = 15;
  localparam int DEF_T_REC     = 10;
  localparam int DEF_DATA_BITS = 64;
  localparam int DEF_CNT_W     = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_CMD_TX,
    S_ROM_RX,
    S_ROM_TX,
    S_DATA_RX,
    S_DONE
  } seq_state_t;

  function automatic logic cmd_is_legal(input logic [7:0] c);
    return (c == CMD_READ_ROM) || (c == CMD_SKIP_ROM) || (c == CMD_MATCH_ROM);
  endfunction

endpackage

// File: rtl/onewire_bit_slot.sv
// One 1-Wire write or read time slot; owns the slot counter and the registered pull-low drive.
// A go on the last slot cycle chains the next slot with no idle gap; force_low overrides for reset pulses.
module onewire_bit_slot
  import onewire_pkg::*;
#(
  parameter int T_SLOT = DEF_T_SLOT,
  parameter int T_LOW1 = DEF_T_LOW1,
  parameter int T_LOW0 = DEF_T_LOW0,
  parameter int T_MSR  = DEF_T_MSR,
  parameter int T_REC  = DEF_T_REC,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic wr_bit,
  input  logic is_read,
  input  logic force_low,
  input  logic bus_s,
  output logic pull_low,
  output logic slot_busy,
  output logic slot_done,
  output logic rd_bit
);

  localparam int LAST = T_SLOT + T_REC - 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] low_len;
  logic             active;
  logic             bit_q;
  logic             read_q;

  // A read slot opens with the same short pulse as a write-1.
  assign low_len   = (read_q || bit_q) ? CNT_W'(T_LOW1) : CNT_W'(T_LOW0);
  assign slot_done = active && (cnt == CNT_W'(LAST));
  assign slot_busy = active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      active   <= 1'b0;
      bit_q    <= 1'b0;
      read_q   <= 1'b0;
      pull_low <= 1'b0;
      rd_bit   <= 1'b0;
    end else begin
      if (go && (!active || slot_done)) begin
        active   <= 1'b1;
        cnt      <= '0;
        bit_q    <= wr_bit;
        read_q   <= is_read;
        pull_low <= 1'b1;
      end else if (slot_done) begin
        active   <= 1'b0;
        cnt      <= '0;
        pull_low <= force_low;
      end else if (active) begin
        cnt      <= cnt + CNT_W'(1);
        pull_low <= force_low || ((cnt + CNT_W'(1)) < low_len);
      end else begin
        pull_low <= force_low;
      end
      if (active && read_q && (cnt == CNT_W'(T_MSR))) begin
        rd_bit <= bus_s;
      end
    end
  end

endmodule

// File: rtl/onewire_master_seq.sv
// 1-Wire master transaction sequencer: reset/presence, ROM command, optional ROM phase, data read.
// Owns reset timing, bit counters and shift registers; slot timing lives in onewire_bit_slot.
module onewire_master_seq
  import onewire_pkg::*;
#(
  parameter int T_RSTL    = DEF_T_RSTL,
  parameter int T_MSP     = DEF_T_MSP,
  parameter int T_RSTH    = DEF_T_RSTH,
  parameter int T_SLOT    = DEF_T_SLOT,
  parameter int T_LOW1    = DEF_T_LOW1,
  parameter int T_LOW0    = DEF_T_LOW0,
  parameter int T_MSR     = DEF_T_MSR,
  parameter int T_REC     = DEF_T_REC,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus,
  output logic        master_pull_low,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [63:0] rom_in,
  output logic        busy,
  output logic        done,
  output logic        presence_ok,
  output logic        error,
  output logic [63:0] rom_out,
  output logic [63:0] data_out
);

  seq_state_t       state, state_nxt;
  logic [1:0]       bus_sync;
  logic             bus_s;
  logic [CNT_W-1:0] tcnt;
  logic [6:0]       bit_cnt;
  logic [6:0]       nbits;
  logic [7:0]       cmd_q;
  logic [63:0]      rom_q;
  logic [63:0]      tx_word;
  logic [5:0]       wr_idx;
  logic             slot_state, last_bit, go, wr_bit, is_read;
  logic             force_low, fail;
  logic             slot_busy, slot_done, rd_bit;

  assign bus_s      = bus_sync[1];
  assign slot_state = (state == S_CMD_TX) || (state == S_ROM_TX) ||
                      (state == S_ROM_RX) || (state == S_DATA_RX);
  assign is_read    = (state == S_ROM_RX) || (state == S_DATA_RX);
  assign nbits      = (state == S_CMD_TX)  ? 7'd8 :
                      (state == S_DATA_RX) ? 7'(DATA_BITS) : 7'd64;
  assign last_bit   = (bit_cnt == nbits - 7'd1);
  assign tx_word    = (state == S_ROM_TX) ? rom_q : {56'd0, cmd_q};
  // When chaining on slot_done the next slot's bit is one ahead of bit_cnt.
  assign wr_idx     = slot_done ? (bit_cnt[5:0] + 6'd1) : bit_cnt[5:0];
  assign wr_bit     = is_read | tx_word[wr_idx];
  assign go         = slot_state && (!slot_busy || (slot_done && !last_bit));
  assign done       = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    force_low = 1'b0;
    fail      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cmd_is_legal(cmd)) begin
            state_nxt = S_RST_LOW;
            force_low = 1'b1;
          end else begin
            state_nxt = S_DONE;
            fail      = 1'b1;
          end
        end
      end
      S_RST_LOW: begin
        force_low = (tcnt < CNT_W'(T_RSTL - 1));
        if (tcnt == CNT_W'(T_RSTL - 1)) state_nxt = S_RST_WAIT;
      end
      S_RST_WAIT: begin
        if (tcnt == CNT_W'(T_RSTH - 1)) begin
          if (presence_ok) begin
            state_nxt = S_CMD_TX;
          end else begin
            state_nxt = S_DONE;
            fail      = 1'b1;
          end
        end
      end
      S_CMD_TX: begin
        if (slot_done && last_bit) begin
          case (cmd_q)
            CMD_READ_ROM:  state_nxt = S_ROM_RX;
            CMD_MATCH_ROM: state_nxt = S_ROM_TX;
            default:       state_nxt = S_DATA_RX;
          endcase
        end
      end
      S_ROM_RX, S_ROM_TX: begin
        if (slot_done && last_bit) state_nxt = S_DATA_RX;
      end
      S_DATA_RX: begin
        if (slot_done && last_bit) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_sync    <= '0;
      tcnt        <= '0;
      bit_cnt     <= '0;
      cmd_q       <= '0;
      rom_q       <= '0;
      busy        <= 1'b0;
      presence_ok <= 1'b0;
      error       <= 1'b0;
      rom_out     <= '0;
      data_out    <= '0;
    end else begin
      bus_sync <= {bus_sync[0], bus};
      if (state_nxt != state) begin
        tcnt <= '0;
      end else if ((state == S_RST_LOW) || (state == S_RST_WAIT)) begin
        tcnt <= tcnt + CNT_W'(1);
      end
      if ((state == S_IDLE) && start) begin
        cmd_q       <= cmd;
        rom_q       <= rom_in;
        busy        <= 1'b1;
        presence_ok <= 1'b0;
        bit_cnt     <= '0;
      end
      if (fail) begin
        error <= 1'b1;
      end else if ((state == S_IDLE) && start) begin
        error <= 1'b0;
      end
      if ((state == S_RST_WAIT) && (tcnt == CNT_W'(T_MSP)) && !bus_s) begin
        presence_ok <= 1'b1;
      end
      if (slot_state && slot_done) begin
        bit_cnt <= last_bit ? 7'd0 : (bit_cnt + 7'd1);
        if (state == S_ROM_RX)  rom_out[bit_cnt[5:0]]  <= rd_bit;
        if (state == S_DATA_RX) data_out[bit_cnt[5:0]] <= rd_bit;
      end
      if (state == S_DONE) busy <= 1'b0;
    end
  end

  onewire_bit_slot #(
    .T_SLOT (T_SLOT),
    .T_LOW1 (T_LOW1),
    .T_LOW0 (T_LOW0),
    .T_MSR  (T_MSR),
    .T_REC  (T_REC),
    .CNT_W  (CNT_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .wr_bit    (wr_bit),
    .is_read   (is_read),
    .force_low (force_low),
    .bus_s     (bus_s),
    .pull_low  (master_pull_low),
    .slot_busy (slot_busy),
    .slot_done (slot_done),
    .rd_bit    (rd_bit)
  );

endmodule

// File: tb/tb_onewire_master_seq.sv
// Bench for onewire_master_seq: behavioural 1-Wire slave plus pulse-width monitor on the bus,
// expectations derived from command semantics and the slot/reset timing rules.
module tb_onewire_master_seq;

  localparam int T_RSTL = 48, T_MSP = 14, T_RSTH = 48, T_SLOT = 20;
  localparam int T_LOW1 = 3, T_LOW0 = 15, T_MSR = 7, T_REC = 4;
  localparam int DATA_BITS = 64, CNT_W = 8, LIMIT = 20000;

  logic clk, reset, bus, master_pull_low, start, busy, done, presence_ok, error;
  logic [7:0]  cmd;
  logic [63:0] rom_in, rom_out, data_out;

  bit          slave_pull, present, prev_mpl, cur_read;
  int          cyc, checks, failures, pulses, rst_pulses, bad, wr_n, done_cnt;
  int          sidx = 1000, rd_hold, pres_t = -1, low_run, rel_cyc;
  logic [7:0]  cmd_rx;
  logic [127:0] wr_vec;
  logic [63:0] slave_rom, slave_data, exp_rom, exp_data;

  assign bus = ~(master_pull_low | slave_pull);

  onewire_master_seq #(
    .T_RSTL(T_RSTL), .T_MSP(T_MSP), .T_RSTH(T_RSTH), .T_SLOT(T_SLOT),
    .T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_MSR(T_MSR), .T_REC(T_REC),
    .DATA_BITS(DATA_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .master_pull_low(master_pull_low),
    .start(start), .cmd(cmd), .rom_in(rom_in), .busy(busy), .done(done),
    .presence_ok(presence_ok), .error(error), .rom_out(rom_out), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: decodes low widths into bits, answers presence and read slots by protocol phase.
  always @(negedge clk) begin
    int idx;
    bit b;
    if (rd_hold > 0) rd_hold--;
    if (pres_t >= 0) begin
      pres_t++;
      if (pres_t >= 30) pres_t = -1;
    end
    if (done) done_cnt++;
    if (master_pull_low) low_run++;
    if (master_pull_low && !prev_mpl) begin
      pulses++;
      b = 1'b1;
      cur_read = 1'b0;
      if (sidx < 8) cur_read = 1'b0;
      else if (sidx < 72 && cmd_rx == 8'h33) begin cur_read = 1'b1; b = slave_rom[sidx-8]; end
      else if (sidx < 72 && cmd_rx == 8'h55) cur_read = 1'b0;
      else begin
        cur_read = 1'b1;
        idx = sidx - ((cmd_rx == 8'h33 || cmd_rx == 8'h55) ? 72 : 8);
        b = (idx < 64) ? slave_data[idx] : 1'b1;
      end
      if (cur_read && !b) rd_hold = 12;
      if (sidx < 100000) sidx++;
    end
    if (!master_pull_low && prev_mpl) begin
      if (low_run >= T_RSTL) begin
        rst_pulses++;
        sidx = 0;
        cmd_rx = 8'h00;
        rel_cyc = cyc;
        if (present) pres_t = 0;
      end else if (!cur_read) begin
        if (low_run == T_LOW1 || low_run == T_LOW0) begin
          b = (low_run == T_LOW1);
          if (wr_n < 128) wr_vec[wr_n] = b;
          wr_n++;
          if (sidx >= 1 && sidx <= 8) cmd_rx[sidx-1] = b;
        end else bad++;
      end else if (low_run != T_LOW1) bad++;
      low_run = 0;
    end
    prev_mpl = master_pull_low;
    slave_pull = (rd_hold > 0) || (pres_t >= 5 && pres_t < 30);
  end

  task automatic run_txn(input string tag, input logic [7:0] c, input logic [63:0] rin,
                         input bit pres, input logic [63:0] srom, input logic [63:0] sdat,
                         input int poke);
    bit legal, got;
    int t0, td, exp_pulses, exp_n, f;
    logic [127:0] exp_vec;
    legal = (c == 8'h33 || c == 8'hCC || c == 8'h55);
    @(negedge clk); #1;
    present = pres; slave_rom = srom; slave_data = sdat;
    wr_n = 0; wr_vec = '0; pulses = 0; rst_pulses = 0; bad = 0; rel_cyc = -1; done_cnt = 0;
    start = 1'b1; cmd = c; rom_in = rin;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    got = 1'b0;
    td = 0;
    for (int k = 0; k < LIMIT; k++) begin
      if (done) begin got = 1'b1; td = cyc; break; end
      start = (k == poke);
      if (k == poke) cmd = 8'h00;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk({tag, "_error"}, error, !(legal && pres));
      chk({tag, "_presence"}, presence_ok, legal && pres);
      if (!legal) chk($sformatf("%s_fast_done_d%0d", tag, td - t0), (td - t0) <= 3, 1);
      if (legal && !pres) chk({tag, "_done_at_rsth"}, td - rel_cyc, T_RSTH);
      if (legal && pres && c == 8'hCC) begin
        f = T_RSTL + T_RSTH + (8 + DATA_BITS) * (T_SLOT + T_REC);
        chk($sformatf("%s_dur_d%0d", tag, td - t0), (td - t0 >= f) && (td - t0 <= f + 4), 1);
      end
    end
    if (legal && pres) begin
      exp_data = sdat;
      if (c == 8'h33) exp_rom = srom;
    end
    exp_vec = '0;
    exp_n = 0;
    exp_pulses = 0;
    if (legal) begin
      exp_pulses = 1;
      if (pres) begin
        exp_vec[7:0] = c;
        exp_n = 8;
        if (c == 8'h55) begin exp_vec[71:8] = rin; exp_n = 72; end
        exp_pulses = 1 + 8 + DATA_BITS + ((c == 8'hCC) ? 0 : 64);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_rom_out"}, rom_out, exp_rom);
    chk({tag, "_data_out"}, data_out, exp_data);
    chk({tag, "_wr_count"}, wr_n, exp_n);
    chk({tag, "_wr_bits"}, wr_vec, exp_vec);
    chk({tag, "_low_pulses"}, pulses, exp_pulses);
    chk({tag, "_bad_widths"}, bad, 0);
  endtask

  initial begin
    logic [7:0] rc;
    int sel;
    reset = 1'b0; start = 1'b0; cmd = 8'h00; rom_in = '0;
    exp_rom = '0; exp_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", {master_pull_low, busy, done, error, presence_ok}, 5'b0);
    chk("rst_rom_data", {rom_out, data_out}, 128'd0);
    reset = 1'b1;

    run_txn("skip", 8'hCC, 64'd0, 1, 64'd0, 64'hA5A5_0F0F_1234_5678, -1);
    run_txn("nopres", 8'hCC, 64'd0, 0, 64'd0, 64'hFFFF_0000_FFFF_0000, -1);
    run_txn("readrom", 8'h33, 64'd0, 1, 64'h2800_0000_ABCD_EF10, {$urandom, $urandom}, -1);
    run_txn("matchrom", 8'h55, 64'h0123_4567_89AB_CDEF, 1, 64'd0, {$urandom, $urandom}, -1);
    run_txn("illegal", 8'h00, 64'd0, 1, 64'd0, 64'd0, -1);
    run_txn("poke", 8'hCC, 64'd0, 1, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 60);

    // Abort inside the first command slot (a write-0 for 0xCC).
    @(negedge clk); #1;
    present = 1'b1; pulses = 0; rst_pulses = 0;
    start = 1'b1; cmd = 8'hCC; rom_in = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < LIMIT && pulses < 2; k++) @(negedge clk);
    chk("abort_slot_reached", pulses, 2);
    repeat (6) @(negedge clk);
    chk("abort_pull_before", master_pull_low, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_pull_now", master_pull_low, 0);
    chk("abort_outputs", {busy, done, error, presence_ok}, 4'b0);
    chk("abort_rom_data", {rom_out, data_out}, 128'd0);
    exp_rom = '0; exp_data = '0;
    @(negedge clk);
    reset = 1'b1;
    run_txn("after_abort", 8'hCC, 64'd0, 1, 64'd0, 64'h0F1E_2D3C_4B5A_6978, -1);

    for (int i = 0; i < 5; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: rc = 8'h33;
        1: rc = 8'hCC;
        2: rc = 8'h55;
        default: begin
          rc = 8'($urandom);
          while (rc == 8'h33 || rc == 8'hCC || rc == 8'h55) rc = 8'($urandom);
        end
      endcase
      if (sel == 4) rc = 8'hCC;
      run_txn($sformatf("rnd%0d", i), rc, {$urandom, $urandom}, (sel != 4),
              {$urandom, $urandom}, {$urandom, $urandom}, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
